mbist_march_ctrl: RTL
=====================

Name: mbist_march_ctrl

Overview:
- Memory BIST initiator that runs a March C- algorithm against a single-port synchronous test memory.
- Drives the memory's write_read, address and wdata pins and checks every read word against the expected value.
- Records the first failure and counts all mismatches.
- Sits between the top-level test-mode logic (start/done/fail) and the memory under test.

Parameters:
DATA_WIDTH, 8, width of one memory word
ADDR_WIDTH, 4, memory address width
LAST_ADDR, 15, highest address tested (N = LAST_ADDR+1 words, addresses 0..LAST_ADDR)
ERR_WIDTH, 8, width of the mismatch counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin a test run; sampled only in IDLE or DONE
mem_write_read  out  1  1 = write, 0 = read, to memory
mem_address  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  write data; leads its write command by one cycle
mem_rdata  in  DATA_WIDTH  memory read data; valid 2 cycles after the read command
busy  out  1  run in progress (RUN or DRAIN)
done  out  1  run complete; held until the next start or reset
fail  out  1  sticky; at least one mismatch in this run
fail_addr  out  ADDR_WIDTH  address of the first mismatch
fail_expected  out  DATA_WIDTH  expected word at the first mismatch
fail_data  out  DATA_WIDTH  read word at the first mismatch
err_count  out  ERR_WIDTH  mismatches this run; saturates at all-ones

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs = 0, including mem_write_read (read) and mem_address.
  - Sequencer and compare pipeline are cleared.
  - Reset mid-run aborts the run with no done pulse.
- March elements, Z = all-zeros word, O = all-ones word:
  - E0 up (wZ)
  - E1 up (rZ, wO)
  - E2 up (rO, wZ)
  - E3 down (rZ, wO)
  - E4 down (rO, wZ)
  - E5 down (rZ)
  - Up = 0..LAST_ADDR; down = LAST_ADDR..0.
  - All ops of an element finish at one address before moving to the next address.
  - Total ops = 10N.
- States:
  - IDLE/DONE: start=1 → RUN; clears fail, err_count, fail_* and done.
  - RUN: the sequencer generates one op per cycle (element, op index, address counter). After the final op of E5 → DRAIN.
  - DRAIN: 3 cycles, letting the command stage and read pipeline empty → DONE (done=1, busy=0).
  - start while busy is ignored.
- Memory timing, fixed by the memory interface:
  - Sequencer op generated in cycle n: mem_wdata = op data in cycle n.
  - mem_write_read and mem_address = op type/address in cycle n+1 (registered command stage).
  - mem_wdata for read ops = don't-care; drive Z.
  - Outside RUN/DRAIN: mem_write_read=0, mem_address=0.
- Read compare:
  - A read command visible in cycle m returns mem_rdata in cycle m+2.
  - A 2-deep valid/expected/address shift register, fed from the command stage, aligns expectations.
  - Compare at the end of cycle m+2.
  - On mismatch: err_count += 1 (saturating).
  - On the first mismatch only: set fail and capture fail_addr, fail_expected, fail_data.
- Read-after-write to the same address on consecutive cycles is legal; the memory returns the new value.
- Timing: start sampled at edge 0 → ops in cycles 1..10N → done rises at edge 10N+3 (N=16: edge 163). busy is high from edge 0 through edge 10N+2.

Test Plan:
- Fault-free memory, N=16, pulse start → 160 ops, done at edge 163, fail=0, err_count=0; mem_wdata leads every write by exactly 1 cycle.
- Transition-coupling fault memory (rising write of bit4 at address 4 forces bit4 of address 5 to 1) → fail=1, fail_addr=5, fail_expected=0x00, fail_data=0x10, err_count=1.
- Memory with bit0 stuck-at-0 at address 3 → first fail at E1 read? No: first fail at E2 read of address 3, fail_expected=0xFF, fail_data=0xFE; err_count=2 (E2 rO and E4 rO).
- rst_n pulled low at cycle 50 of a run → all outputs 0 asynchronously, no done; next start runs the full 160-op sequence cleanly.
- start asserted again during RUN → ignored, op sequence unchanged; start in DONE → fail/err_count/done cleared and a new run begins.
- Memory returning 0x5A on every read, ERR_WIDTH=4 → err_count saturates at 15, fail_addr=0, fail_expected=0x00.

Source files
------------

// File: rtl/mbist_march_ctrl_if.sv
// Memory-under-test port bundle: the BIST controller is master, the memory is slave.
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
   logic                  mem_write_read;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_write_read,
      output mem_address,
      output mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_write_read,
      input  mem_address,
      input  mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer for a single-port synchronous memory with two-cycle read latency.
// Records the first mismatch and counts all mismatches with a saturating counter.
module mbist_march_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int LAST_ADDR  = 15,
   parameter int ERR_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   mbist_march_ctrl_if.master    mem,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_expected,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic [ERR_WIDTH-1:0]  err_count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
   localparam logic [DATA_WIDTH-1:0] ONES = '1;

   function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
      return (v == '1) ? v : v + ERR_WIDTH'(1);
   endfunction

   state_t                state_q, state_d;
   logic [2:0]            elem_q, elem_d;
   logic                  op_q, op_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            drain_q, drain_d;
   logic                  clr;

   logic                  run, op_wr, last_op, down, addr_end;
   logic [DATA_WIDTH-1:0] op_data;

   logic                  wr_p0, rd_p0, vld_p1, vld_p2;
   logic [ADDR_WIDTH-1:0] addr_p0, addr_p1, addr_p2;
   logic [DATA_WIDTH-1:0] exp_p0, exp_p1, exp_p2;
   logic                  mism;

   // Op decode: op 0 of E1..E5 is a read, everything else writes.
   // Reads of E2/E4 expect ones; writes of E1/E3 store ones.
   assign run      = (state_q == RUN);
   assign op_wr    = (elem_q == 3'd0) || op_q;
   assign op_data  = op_wr ? (((elem_q == 3'd1) || (elem_q == 3'd3)) ? ONES : '0)
                           : (((elem_q == 3'd2) || (elem_q == 3'd4)) ? ONES : '0);
   assign last_op  = ((elem_q == 3'd0) || (elem_q == 3'd5)) ? 1'b1 : op_q;
   assign down     = (elem_q >= 3'd3);
   assign addr_end = down ? (addr_q == '0) : (addr_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         elem_q  <= '0;
         op_q    <= 1'b0;
         addr_q  <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      elem_d        = elem_q;
      op_d          = op_q;
      addr_d        = addr_q;
      drain_d       = drain_q;
      clr           = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      mem.mem_wdata = (run && op_wr) ? op_data : '0;
      case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (start) begin
               state_d = RUN;
               elem_d  = '0;
               op_d    = 1'b0;
               addr_d  = '0;
               clr     = 1'b1;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (!last_op) begin
               op_d = 1'b1;
            end else if (!addr_end) begin
               op_d   = 1'b0;
               addr_d = down ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
            end else if (elem_q == 3'd5) begin
               state_d = DRAIN;
               drain_d = '0;
            end else begin
               elem_d = elem_q + 3'd1;
               op_d   = 1'b0;
               addr_d = (elem_q >= 3'd2) ? LAST : '0;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_q == 2'd2) state_d = DONE;
            else                 drain_d = drain_q + 2'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Command stage: write/read and address trail the write data by one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_p0   <= 1'b0;
         rd_p0   <= 1'b0;
         addr_p0 <= '0;
         exp_p0  <= '0;
      end else begin
         wr_p0   <= run && op_wr;
         rd_p0   <= run && !op_wr;
         addr_p0 <= run ? addr_q : '0;
         exp_p0  <= run ? op_data : '0;
      end
   end

   assign mem.mem_write_read = wr_p0;
   assign mem.mem_address    = addr_p0;

   // Read alignment stages p1/p2 match the memory's two-cycle read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
         exp_p1  <= '0;
         vld_p2  <= 1'b0;
         addr_p2 <= '0;
         exp_p2  <= '0;
      end else begin
         vld_p1  <= rd_p0;
         addr_p1 <= addr_p0;
         exp_p1  <= exp_p0;
         vld_p2  <= vld_p1;
         addr_p2 <= addr_p1;
         exp_p2  <= exp_p1;
      end
   end

   assign mism = vld_p2 && (mem.mem_rdata != exp_p2);

   // Compare stage: first mismatch is captured, later ones only counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail          <= 1'b0;
         fail_addr     <= '0;
         fail_expected <= '0;
         fail_data     <= '0;
         err_count     <= '0;
      end else if (clr) begin
         fail          <= 1'b0;
         fail_addr     <= '0;
         fail_expected <= '0;
         fail_data     <= '0;
         err_count     <= '0;
      end else if (mism) begin
         err_count <= sat_inc(err_count);
         if (!fail) begin
            fail          <= 1'b1;
            fail_addr     <= addr_p2;
            fail_expected <= exp_p2;
            fail_data     <= mem.mem_rdata;
         end
      end
   end

endmodule
